// File: rtl/bpu_table_ctrl.sv
// Write-port arbiter for a branch-prediction table: a clear sweep after reset or flush,
// then registered single-cycle ID-stage updates once the table is ready.
module bpu_table_ctrl #(
    parameter int unsigned      IDX_W    = 13,
    parameter int unsigned      ENT_W    = 47,
    parameter logic [ENT_W-1:0] CLR_DATA = ENT_W'(2) << 32
) (
    input  logic             cpu_clk,
    input  logic             cpu_rstn,
    input  logic             flush_req,
    input  logic             upd_req,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic [ENT_W-1:0] upd_wdata,
    output logic             upd_ack,
    output logic             tbl_we,
    output logic [IDX_W-1:0] tbl_widx,
    output logic [ENT_W-1:0] tbl_wdata,
    output logic             pred_en,
    output logic             clr_done
);

    typedef enum logic [0:0] {StClear, StReady} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [IDX_W-1:0]   widx_q, widx_d;
    logic [ENT_W-1:0]   wdata_q, wdata_d;
    logic               pred_q, pred_d;
    logic               done_q, done_d;
    logic               last_idx;

    assign last_idx = (cnt_q == {IDX_W{1'b1}});

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q <= StClear;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StClear: if (!flush_req && last_idx) state_d = StReady;
            StReady: if (flush_req)              state_d = StClear;
            default: state_d = StClear;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        widx_d  = widx_q;
        wdata_d = wdata_q;
        pred_d  = pred_q;
        done_d  = 1'b0;
        upd_ack = 1'b0;
        unique case (state_q)
            StClear: begin
                we_d    = 1'b1;
                wdata_d = CLR_DATA;
                if (flush_req) begin
                    // Restart in place: this edge writes index 0, so the sweep resumes at 1.
                    widx_d = '0;
                    cnt_d  = IDX_W'(1);
                end else begin
                    widx_d = cnt_q;
                    cnt_d  = cnt_q + IDX_W'(1);
                    if (last_idx) begin
                        pred_d = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            StReady: begin
                if (flush_req) begin
                    cnt_d  = '0;
                    pred_d = 1'b0;
                end else if (upd_req) begin
                    upd_ack = 1'b1;
                    we_d    = 1'b1;
                    widx_d  = upd_idx;
                    wdata_d = upd_wdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            cnt_q   <= '0;
            we_q    <= 1'b0;
            widx_q  <= '0;
            wdata_q <= '0;
            pred_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            widx_q  <= widx_d;
            wdata_q <= wdata_d;
            pred_q  <= pred_d;
            done_q  <= done_d;
        end
    end

    assign tbl_we    = we_q;
    assign tbl_widx  = widx_q;
    assign tbl_wdata = wdata_q;
    assign clr_done  = done_q;
    // Predictions are withdrawn already in the cycle a flush is presented.
    assign pred_en   = pred_q & ~flush_req;

endmodule

// File: tb/tb_bpu_table_ctrl.sv
// Self-checking bench for bpu_table_ctrl (IDX_W=4): directed scenarios plus a random phase,
// compared against a sweep/ready reference model.
module tb_bpu_table_ctrl;

    localparam int unsigned IDX_W = 4;
    localparam int unsigned ENT_W = 47;
    localparam int unsigned DEPTH = 1 << IDX_W;

    logic             cpu_clk;
    logic             cpu_rstn;
    logic             flush_req;
    logic             upd_req;
    logic [IDX_W-1:0] upd_idx;
    logic [ENT_W-1:0] upd_wdata;
    logic             upd_ack;
    logic             tbl_we;
    logic [IDX_W-1:0] tbl_widx;
    logic [ENT_W-1:0] tbl_wdata;
    logic             pred_en;
    logic             clr_done;

    bpu_table_ctrl #(
        .IDX_W (IDX_W),
        .ENT_W (ENT_W)
    ) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rstn  (cpu_rstn),
        .flush_req (flush_req),
        .upd_req   (upd_req),
        .upd_idx   (upd_idx),
        .upd_wdata (upd_wdata),
        .upd_ack   (upd_ack),
        .tbl_we    (tbl_we),
        .tbl_widx  (tbl_widx),
        .tbl_wdata (tbl_wdata),
        .pred_en   (pred_en),
        .clr_done  (clr_done)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    // Clear entry: valid=0, tag=0, history=2'b10, target=0.
    logic [ENT_W-1:0] clr_val;

    int tests;
    int fails;

    // Reference model: "clearing" with next sweep position, or "ready".
    bit               m_ready;
    int               m_pos;
    bit               m_we;
    int               m_widx;
    logic [ENT_W-1:0] m_wdata;
    bit               m_pred;
    bit               m_done;

    logic [ENT_W-1:0] shadow [DEPTH];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ready = 0; m_pos = 0; m_we = 0; m_widx = 0; m_wdata = '0; m_pred = 0; m_done = 0;
    endtask

    task automatic model_edge(input bit f, input bit r, input int idx, input logic [ENT_W-1:0] d);
        m_done = 0;
        if (!m_ready) begin
            m_we = 1;
            m_wdata = clr_val;
            if (f) begin
                m_widx = 0;
                m_pos = 1;
            end else begin
                m_widx = m_pos;
                if (m_pos == DEPTH - 1) begin
                    m_ready = 1; m_pred = 1; m_done = 1; m_pos = 0;
                end else begin
                    m_pos++;
                end
            end
        end else if (f) begin
            m_ready = 0; m_pos = 0; m_pred = 0; m_we = 0;
        end else if (r) begin
            m_we = 1; m_widx = idx; m_wdata = d;
        end else begin
            m_we = 0;
        end
    endtask

    // One clock: drive inputs, check combinational outputs, then check registered outputs.
    task automatic cycle(input bit f, input bit r, input int idx, input logic [ENT_W-1:0] d);
        flush_req = f;
        upd_req   = r;
        upd_idx   = IDX_W'(idx);
        upd_wdata = d;
        #1;
        check("upd_ack", 64'(upd_ack), 64'(m_ready && r && !f));
        check("pred_en", 64'(pred_en), 64'(m_pred && !f));
        @(posedge cpu_clk);
        #1;
        model_edge(f, r, idx, d);
        check("tbl_we", 64'(tbl_we), 64'(m_we));
        check("tbl_widx", 64'(tbl_widx), 64'(m_widx));
        check("tbl_wdata", 64'(tbl_wdata), 64'(m_wdata));
        check("clr_done", 64'(clr_done), 64'(m_done));
        if (tbl_we) shadow[tbl_widx] = tbl_wdata;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, '0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_we"}, 64'(tbl_we), 64'(0));
        check({tag, "_widx"}, 64'(tbl_widx), 64'(0));
        check({tag, "_wdata"}, 64'(tbl_wdata), 64'(0));
        check({tag, "_pred"}, 64'(pred_en), 64'(0));
        check({tag, "_done"}, 64'(clr_done), 64'(0));
        check({tag, "_ack"}, 64'(upd_ack), 64'(0));
    endtask

    task automatic shadow_poison();
        for (int i = 0; i < DEPTH; i++) shadow[i] = {ENT_W{1'b1}};
    endtask

    task automatic shadow_check(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (shadow[i] !== clr_val) bad++;
        check(tag, 64'(bad), 64'(0));
    endtask

    // Advance with idle (or held-request) cycles until the model issues clear write `idx`.
    task automatic run_to_clear_idx(input int idx, input bit hold_req);
        bit found;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(0, hold_req, $urandom_range(0, DEPTH - 1), '0);
            if (!m_ready && m_we && m_widx == idx) found = 1;
        end
        check("wait_bound", 64'(found), 64'(1));
    endtask

    initial begin
        logic [ENT_W-1:0] rd;
        tests = 0;
        fails = 0;
        clr_val = {1'b0, 12'h000, 2'b10, 32'h0000_0000};
        flush_req = 0; upd_req = 0; upd_idx = '0; upd_wdata = '0;
        model_reset();

        // Reset and first sweep
        cpu_rstn = 1'b0;
        @(posedge cpu_clk);
        #1;
        check_zero_outputs("rst");
        cpu_rstn = 1'b1;
        shadow_poison();
        idle(DEPTH);
        check("sweep_ready", 64'(m_ready), 64'(1));
        shadow_check("sweep_table");
        idle(2);

        // Single update
        cycle(0, 1, 5, 47'h1_2345_6789);
        cycle(0, 0, 0, '0);

        // Flush beats a simultaneous update, then a full sweep
        cycle(1, 1, 5, 47'h0_dead_beef);
        shadow_poison();
        idle(DEPTH + 1);
        shadow_check("flush_table");

        // Requests held across a sweep are dropped
        cycle(1, 1, 3, 47'h7_0000_0001);
        for (int i = 0; i < DEPTH + 1; i++) cycle(0, 1, i % DEPTH, 47'(64'h55 + i));
        cycle(0, 1, 2, 47'h0_1111_2222);

        // Flush mid-sweep after index 9 is issued
        cycle(1, 0, 0, '0);
        run_to_clear_idx(9, 0);
        shadow_poison();
        cycle(1, 0, 0, '0);
        idle(DEPTH);
        shadow_check("restart_table");

        // Flush on the final-index edge
        cycle(1, 0, 0, '0);
        run_to_clear_idx(DEPTH - 2, 0);
        cycle(1, 0, 0, '0);
        idle(DEPTH);

        // Reset pulse between edges during a sweep
        cycle(1, 0, 0, '0);
        run_to_clear_idx(7, 1);
        upd_req = 1'b0;
        #1 cpu_rstn = 1'b0;
        #1;
        check_zero_outputs("midrst");
        #1 cpu_rstn = 1'b1;
        model_reset();
        idle(DEPTH + 2);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rd = 47'({$urandom(), $urandom()});
            cycle($urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, DEPTH - 1), rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
